seg_scan_decoder: RTL
=====================

# seg_scan_decoder

Receive-side counterpart to the board's multiplexed seven-segment driver: samples the scanned anode-select and segment lines and reconstructs the eight displayed hex digits into a register file. Used as an in-fabric loopback monitor beside `top`, so benches and on-chip self-checks can read what the display is showing without decoding waveforms. Detects settled dwell periods, decodes each segment pattern to a nibble, and flags complete frames and illegal patterns.

## Interface
- `SETTLE_CYCLES`, default 4: consecutive cycles with `ans` and `seg` unchanged before a sample is taken; legal range 1–255.
- `NUM_DIGITS`, default 8: number of anode lines and digit slots.

- `hclk`  in  1  system clock
- `rst_n`  in  1  asynchronous, active-low reset
- `ans`  in  NUM_DIGITS  anode select, active-low, one-hot-low while scanning; all-ones = blanked
- `seg`  in  7  segments a..g on bits 0..6, active-low
- `digits`  out  4*NUM_DIGITS  decoded nibble per slot; slot i at bits [4i+3:4i]
- `digit_valid`  out  NUM_DIGITS  slot i holds a decoded hex value
- `digit_blank`  out  NUM_DIGITS  slot i last sampled as blank (`seg` = 7'h7F)
- `frame_done`  out  1  one-cycle pulse when every slot has been sampled since the previous pulse
- `err`  out  1  one-cycle pulse on an illegal settled sample

## Operation
- Reset values: `digits` 0, `digit_valid` 0, `digit_blank` 0, `frame_done` 0, `err` 0; FSM in IDLE; stability counter 0; frame-seen mask 0.
- Stability counter: cleared on any cycle where `{ans,seg}` differs from the previous cycle's value; otherwise it increments and saturates at SETTLE_CYCLES.
- FSM states:
  - IDLE: `ans` all-ones. Nothing is sampled. Moves to SETTLE on any change.
  - SETTLE: waits for the counter to reach SETTLE_CYCLES, then moves to SAMPLE. Returns to SETTLE on any input change.
  - SAMPLE: single cycle. Evaluates `ans` and `seg`, writes the slot, then moves to HOLD.
  - HOLD: no further samples. An `ans` or `seg` change moves to SETTLE, or to IDLE if the new `ans` is all-ones.
- Sample rules:
  - `ans` not one-hot-low and not all-ones: pulse `err`; no slot write.
  - `seg` = 7'h7F: set `digit_blank[i]`, clear `digit_valid[i]`, leave the nibble unchanged, mark slot i seen.
  - `seg` in the decode table: write the nibble, set `digit_valid[i]`, clear `digit_blank[i]`, mark slot i seen.
  - Any other `seg` pattern: pulse `err`, clear `digit_valid[i]`, mark slot i seen.
- Decode table (active-low `seg` -> hex):
  - 0: 40, 1: 79, 2: 24, 3: 30, 4: 19, 5: 12, 6: 02, 7: 78
  - 8: 00, 9: 10, A: 08, b: 03, C: 46, d: 21, E: 06, F: 0E
- Frame completion: when the seen mask becomes all-ones, pulse `frame_done` and clear the mask in the same cycle. A slot sampled again before the frame completes is overwritten and does not double-count.
- Reset mid-dwell: all state clears immediately; the first sample after release needs a full SETTLE_CYCLES of stable input.

## Timing
- Sample latency: with inputs changing at edge N, outputs update at edge N+SETTLE_CYCLES+1, visible in the following cycle.
- `frame_done` and `err` assert in the same cycle the slot outputs update.
- Input changes every cycle: no sample is ever taken and no `err` is raised.
- Simultaneous frame completion and illegal `seg` pattern: both `frame_done` and `err` pulse.

## Configuration
- `SEG_SCAN_SYNC_EN` defined: `ans` and `seg` pass through a two-flop synchronizer reset to all-ones before the stability logic. All latencies grow by 2 cycles. Use this when inputs come from pins.
- `SEG_SCAN_SYNC_EN` undefined: inputs feed the stability logic directly. Use this for same-clock internal loopback.

## Structure
- Shared package `seg_scan_pkg`: FSM state enum, `SEG_BLANK` = 7'h7F, and the 16-entry decode constants.
- One sub-module, `seg7_to_hex`: combinational; `seg` in, nibble plus `hit` out.
- The top level holds the synchronizer, counter, FSM, slot registers and seen mask.

## Test plan
- Reset check: release `rst_n` with `ans`=8'hFF. All outputs stay 0 and the FSM stays in IDLE for 20 cycles.
- Single dwell: `ans`=8'hFE, `seg`=7'h30 held for 10 cycles. After 5 cycles, `digits[3:0]`=3 and `digit_valid`=8'h01. No `err`.
- Full scan: slots 0..7 each show digits 0..7, each for 8 cycles. One `frame_done` pulse at slot 7's sample; `digits`=32'h76543210.
- Glitch rejection: toggle `seg` each cycle for 3 cycles mid-dwell, then hold 7'h00. Slot updates to 8 exactly SETTLE_CYCLES+1 cycles after the last toggle; only one write occurs.
- Illegal inputs: `ans`=8'hFC held gives a single `err` pulse and no slot change. `ans`=8'hFB with `seg`=7'h55 gives an `err` pulse and `digit_valid[2]`=0.
- Blank and mid-dwell reset: `seg`=7'h7F on slot 1 sets `digit_blank[1]`. Asserting `rst_n` low during a SETTLE clears all outputs within the same cycle.

Source files
------------

// File: rtl/seg_scan_pkg.sv
// Shared definitions for the seven-segment scan decoder: FSM state codes,
// the blank segment pattern and the active-low hex glyph table.
package seg_scan_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_SAMPLE = 2'd2;
    localparam logic [1:0] ST_HOLD   = 2'd3;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low a..g pattern shown for each hex value
    function automatic logic [6:0] seg_code(input logic [3:0] n);
        logic [6:0] c;
        case (n)
            4'h0: c = 7'h40;
            4'h1: c = 7'h79;
            4'h2: c = 7'h24;
            4'h3: c = 7'h30;
            4'h4: c = 7'h19;
            4'h5: c = 7'h12;
            4'h6: c = 7'h02;
            4'h7: c = 7'h78;
            4'h8: c = 7'h00;
            4'h9: c = 7'h10;
            4'hA: c = 7'h08;
            4'hB: c = 7'h03;
            4'hC: c = 7'h46;
            4'hD: c = 7'h21;
            4'hE: c = 7'h06;
            4'hF: c = 7'h0E;
            default: c = SEG_BLANK;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/seg_scan_decoder_seg7_to_hex.sv
// Combinational reverse lookup: active-low segment pattern to hex nibble.
// hit is low when the pattern is not one of the 16 hex glyphs.
module seg7_to_hex
    import seg_scan_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] nibble,
    output logic       hit
);

    // Search the glyph table; the patterns are unique so at most one matches
    always_comb begin
        nibble = 4'h0;
        hit    = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (seg == seg_code(4'(i))) begin
                nibble = 4'(i);
                hit    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/seg_scan_decoder.sv
// Loopback monitor for the multiplexed seven-segment driver. Waits for the
// scanned anode/segment lines to settle, decodes each dwell into its digit
// slot and flags completed frames and illegal patterns.
// Optional macro SEG_SCAN_SYNC_EN adds a two-flop input synchronizer for
// pin-sourced inputs (adds 2 cycles of latency).
module seg_scan_decoder
    import seg_scan_pkg::*;
#(
    parameter int SETTLE_CYCLES = 4,
    parameter int NUM_DIGITS    = 8
) (
    input  logic                    hclk,
    input  logic                    rst_n,
    input  logic [NUM_DIGITS-1:0]   ans,
    input  logic [6:0]              seg,
    output logic [4*NUM_DIGITS-1:0] digits,
    output logic [NUM_DIGITS-1:0]   digit_valid,
    output logic [NUM_DIGITS-1:0]   digit_blank,
    output logic                    frame_done,
    output logic                    err
);

    localparam int                    W      = NUM_DIGITS + 7;
    localparam logic [7:0]            SETTLE = 8'(SETTLE_CYCLES);
    localparam logic [NUM_DIGITS-1:0] ONE    = NUM_DIGITS'(1);

    logic [NUM_DIGITS-1:0] ans_s;
    logic [6:0]            seg_s;

`ifdef SEG_SCAN_SYNC_EN
    logic [W-1:0] sync1, sync2;

    // Two-flop synchronizer; idles at all-ones so reset looks like a blanked display
    always_ff @(posedge hclk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '1;
            sync2 <= '1;
        end else begin
            sync1 <= {ans, seg};
            sync2 <= sync1;
        end
    end
    assign {ans_s, seg_s} = sync2;
`else
    assign ans_s = ans;
    assign seg_s = seg;
`endif

    logic [W-1:0]          prev;
    logic [7:0]            cnt, cnt_nx;
    logic [1:0]            state, state_nx;
    logic [NUM_DIGITS-1:0] sel, seen, seen_set;
    logic                  changed, do_sample, blanked, onehot, is_blank, hit;
    logic [3:0]            nib;

    seg7_to_hex u_dec (
        .seg    (seg_s),
        .nibble (nib),
        .hit    (hit)
    );

    assign changed   = ({ans_s, seg_s} != prev);
    assign cnt_nx    = changed ? 8'd0 : (cnt == SETTLE) ? cnt : cnt + 8'd1;
    // The slot registers load on the edge that enters SAMPLE, which gives
    // SETTLE_CYCLES+1 edges from an input change to updated outputs.
    assign do_sample = (state == ST_SETTLE) && !changed && (cnt_nx == SETTLE);
    assign sel       = ~ans_s;
    assign blanked   = &ans_s;
    assign onehot    = (sel != '0) && ((sel & (sel - ONE)) == '0);
    assign is_blank  = (seg_s == SEG_BLANK);
    assign seen_set  = seen | sel;

    // Dwell state machine next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:   if (changed) state_nx = ST_SETTLE;
            ST_SETTLE: if (do_sample) state_nx = ST_SAMPLE;
            ST_SAMPLE: state_nx = changed ? (blanked ? ST_IDLE : ST_SETTLE) : ST_HOLD;
            ST_HOLD:   if (changed) state_nx = blanked ? ST_IDLE : ST_SETTLE;
            default:   state_nx = ST_IDLE;
        endcase
    end

    // Previous-input register, saturating stability counter and FSM state.
    // prev resets to all-ones so the first post-reset dwell needs a full settle.
    always_ff @(posedge hclk or negedge rst_n) begin
        if (!rst_n) begin
            prev  <= '1;
            cnt   <= 8'd0;
            state <= ST_IDLE;
        end else begin
            prev  <= {ans_s, seg_s};
            cnt   <= cnt_nx;
            state <= state_nx;
        end
    end

    // Slot writes, seen mask and the one-cycle status pulses
    always_ff @(posedge hclk or negedge rst_n) begin
        if (!rst_n) begin
            digits      <= '0;
            digit_valid <= '0;
            digit_blank <= '0;
            seen        <= '0;
            frame_done  <= 1'b0;
            err         <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            err        <= 1'b0;
            if (do_sample && !blanked) begin
                if (!onehot) begin
                    err <= 1'b1;
                end else begin
                    if (!is_blank && !hit) err <= 1'b1;
                    for (int i = 0; i < NUM_DIGITS; i++) begin
                        if (sel[i]) begin
                            if (is_blank) begin
                                digit_blank[i] <= 1'b1;
                                digit_valid[i] <= 1'b0;
                            end else if (hit) begin
                                digits[4*i +: 4] <= nib;
                                digit_valid[i]   <= 1'b1;
                                digit_blank[i]   <= 1'b0;
                            end else begin
                                digit_valid[i] <= 1'b0;
                            end
                        end
                    end
                    if (&seen_set) begin
                        frame_done <= 1'b1;
                        seen       <= '0;
                    end else begin
                        seen <= seen_set;
                    end
                end
            end
        end
    end

endmodule
